// File: rtl/synth_pkg.sv
// Shared types and constants for the wave shaper voice datapath.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    SHAPE = 2'd2
  } shaper_state_t;

  localparam logic [7:0]  MIDSCALE  = 8'h80;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Serial restoring divider producing floor(c*2^STEPS/d) for c<d, one bit per clock.
module serial_divider #(
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             abort,
  input  logic             start,
  input  logic [15:0]      c,
  input  logic [15:0]      d,
  output logic [STEPS-1:0] q,
  output logic             done
);

  localparam int SW = $clog2(STEPS + 1);
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  logic [16:0]      rem_q, rem_d;
  logic [15:0]      den_q, den_d;
  logic [STEPS-1:0] quo_q, quo_d;
  logic [SW-1:0]    step_q, step_d;
  logic             active_q, active_d;
  logic             force_q, force_d;
  logic [16:0]      shifted_s, diff_s;
  logic             ge_s;

  // Next-state for one restoring step; special cases pin the quotient but keep the step count.
  always_comb begin
    shifted_s = {rem_q[15:0], 1'b0};
    ge_s      = (shifted_s >= {1'b0, den_q});
    diff_s    = shifted_s - {1'b0, den_q};
    rem_d     = rem_q;
    den_d     = den_q;
    quo_d     = quo_q;
    step_d    = step_q;
    active_d  = active_q;
    force_d   = force_q;
    if (abort) begin
      active_d = 1'b0;
      step_d   = '0;
    end else if (start) begin
      rem_d    = {1'b0, c};
      den_d    = d;
      step_d   = '0;
      active_d = 1'b1;
      if (d == 16'h0000) begin
        quo_d   = '0;
        force_d = 1'b1;
      end else if (c >= d) begin
        quo_d   = '1;
        force_d = 1'b1;
      end else begin
        quo_d   = '0;
        force_d = 1'b0;
      end
    end else if (active_q) begin
      rem_d  = ge_s ? diff_s : shifted_s;
      step_d = step_q + SW'(1);
      if (force_q) begin
        quo_d = quo_q;
      end else begin
        quo_d = {quo_q[STEPS-2:0], ge_s};
      end
      if (step_q == LAST) begin
        active_d = 1'b0;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem_q    <= 17'h0;
      den_q    <= 16'h0;
      quo_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
      force_q  <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      den_q    <= den_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      active_q <= active_d;
      force_q  <= force_d;
    end
  end

  assign q    = quo_q;
  assign done = active_q && (step_q == LAST);

endmodule

// File: rtl/wave_shaper.sv
// Voice wave shaper: phase snapshot on sample tick, serial divide, waveform mapping.
// Optional macro WAVE_NOISE_EN adds an LFSR noise source for mode 3.
module wave_shaper #(
  parameter int         DIV_STEPS = 8,
  parameter logic [7:0] MIDSCALE  = synth_pkg::MIDSCALE
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        sample_tick,
  input  logic [15:0] count,
  input  logic [15:0] divider,
  input  logic [1:0]  mode,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        busy
);
  import synth_pkg::*;

  shaper_state_t  state_q, state_d;
  wave_mode_t     mode_q, mode_d;
  logic [7:0]     sample_q, sample_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           start_s, div_done_s;
  logic [DIV_STEPS-1:0] quo_s;
  logic [7:0]     shaped_s;
  logic [7:0]     noise_s;

  serial_divider #(.STEPS(DIV_STEPS)) u_div (
    .clk   (clk),
    .n_rst (n_rst),
    .abort (~enable),
    .start (start_s),
    .c     (count),
    .d     (divider),
    .q     (quo_s),
    .done  (div_done_s)
  );

`ifdef WAVE_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Noise source advances once per accepted tick.
  always_comb begin
    if (start_s) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noise_s = lfsr_q[15:8];
`else
  assign noise_s = MIDSCALE;
`endif

  // Phase-to-waveform mapping from the completed quotient.
  always_comb begin
    shaped_s = MIDSCALE;
    case (mode_q)
      WAVE_SQUARE: shaped_s = quo_s[7] ? 8'h00 : 8'hFF;
      WAVE_SAW:    shaped_s = quo_s[7:0];
      WAVE_TRI:    shaped_s = quo_s[7] ? {~quo_s[6:0], 1'b0} : {quo_s[6:0], 1'b0};
      WAVE_NOISE:  shaped_s = noise_s;
      default:     shaped_s = MIDSCALE;
    endcase
  end

  // Control FSM; enable low overrides everything and silences the voice.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    start_s  = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      sample_d = MIDSCALE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_d = DIV;
            start_s = 1'b1;
            mode_d  = wave_mode_t'(mode);
          end else begin
            state_d = IDLE;
          end
        end
        DIV: begin
          if (div_done_s) begin
            state_d = SHAPE;
          end else begin
            state_d = DIV;
          end
        end
        SHAPE: begin
          sample_d = shaped_s;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      mode_q   <= WAVE_SQUARE;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_wave_shaper.sv
// Directed self-checking bench for wave_shaper (noise expectations follow WAVE_NOISE_EN).
module tb_wave_shaper;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        enable;
  logic        sample_tick;
  logic [15:0] count;
  logic [15:0] divider;
  logic [1:0]  mode;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] lfsr_m;

  wave_shaper dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .count        (count),
    .divider      (divider),
    .mode         (mode),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s[0]) lfsr_step = (s >> 1) ^ 16'hB400;
    else      lfsr_step = s >> 1;
  endfunction

  // Issue one accepted tick and watch 12 following edges for valid pulses.
  task automatic run_tick(input logic [15:0] c, input logic [15:0] d, input logic [1:0] m,
                          output int lat, output int pulses, output logic [7:0] val,
                          output logic busy_seen);
    @(negedge clk);
    count = c; divider = d; mode = m; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    busy_seen = busy;
    lfsr_m = lfsr_step(lfsr_m);
    lat = 0; pulses = 0; val = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (sample_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          val = sample;
        end
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enable = 1'b1; sample_tick = 1'b0;
    count = 16'd0; divider = 16'd0; mode = 2'd0;
    lfsr_m = 16'hACE1;
    #23;
    checks += 3;
    if (sample !== 8'h80) begin failures++; $display("FAIL reset_sample actual=%h required=80", sample); end
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", sample_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_vectors(input string name, input logic [15:0] c, input logic [15:0] d,
                              input logic [1:0] m, input logic [7:0] exp);
    int lat, pulses; logic [7:0] val; logic bs;
    run_tick(c, d, m, lat, pulses, val, bs);
    checks += 4;
    if (lat !== 9) begin failures++; $display("FAIL %s_latency actual=%0d required=9", name, lat); end
    if (pulses !== 1) begin failures++; $display("FAIL %s_pulses actual=%0d required=1", name, pulses); end
    if (val !== exp) begin failures++; $display("FAIL %s_value actual=%h required=%h", name, val, exp); end
    if (bs !== 1'b1) begin failures++; $display("FAIL %s_busy actual=%b required=1", name, bs); end
  endtask

  task automatic test_saw();
    test_vectors("saw_half", 16'd500, 16'd1000, 2'd1, 8'h80);
    test_vectors("saw_quarter", 16'd250, 16'd1000, 2'd1, 8'h40);
    test_vectors("saw_clamp", 16'd1000, 16'd1000, 2'd1, 8'hFF);
  endtask

  task automatic test_tri_square();
    test_vectors("tri_rise", 16'd64, 16'd256, 2'd2, 8'h80);
    test_vectors("tri_fall", 16'd192, 16'd256, 2'd2, 8'h7E);
    test_vectors("sq_low", 16'd64, 16'd256, 2'd0, 8'hFF);
    test_vectors("sq_high", 16'd192, 16'd256, 2'd0, 8'h00);
  endtask

  task automatic test_div_zero();
    test_vectors("div0_a", 16'd1234, 16'd0, 2'd1, 8'h00);
    test_vectors("div0_b", 16'd0, 16'd0, 2'd1, 8'h00);
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    count = 16'd250; divider = 16'd1000; mode = 2'd1; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    lfsr_m = 16'hACE1;
    checks += 3;
    if (sample !== 8'h80) begin failures++; $display("FAIL rstmid_sample actual=%h required=80", sample); end
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid actual=%b required=0", sample_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy actual=%b required=0", busy); end
    @(negedge clk);
    n_rst = 1'b1;
    test_vectors("after_rst", 16'd250, 16'd1000, 2'd1, 8'h40);
  endtask

  task automatic test_back_to_back();
    int lat = 0, pulses = 0; logic [7:0] val = 8'h00;
    @(negedge clk);
    count = 16'd500; divider = 16'd1000; mode = 2'd1; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    lfsr_m = lfsr_step(lfsr_m);
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        count = 16'd10; divider = 16'd40; mode = 2'd0; sample_tick = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 3) sample_tick = 1'b0;
      if (sample_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = k; val = sample; end
      end
    end
    checks += 3;
    if (pulses !== 1) begin failures++; $display("FAIL b2b_pulses actual=%0d required=1", pulses); end
    if (lat !== 9) begin failures++; $display("FAIL b2b_latency actual=%0d required=9", lat); end
    if (val !== 8'h80) begin failures++; $display("FAIL b2b_value actual=%h required=80", val); end
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    test_vectors("pre_drop", 16'd750, 16'd1000, 2'd1, 8'hC0);
    @(negedge clk);
    count = 16'd250; divider = 16'd1000; mode = 2'd1; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    lfsr_m = lfsr_step(lfsr_m);
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (sample !== 8'h80) begin failures++; $display("FAIL drop_sample actual=%h required=80", sample); end
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL drop_valid actual=%b required=0", sample_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy actual=%b required=0", busy); end
    sample_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      sample_tick = 1'b0;
      if (sample_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks += 1;
    if (pulses !== 0) begin failures++; $display("FAIL drop_activity actual=%0d required=0", pulses); end
    enable = 1'b1;
  endtask

  task automatic test_noise();
    int lat, pulses; logic [7:0] val, exp; logic bs;
    for (int i = 0; i < 2; i++) begin
      run_tick(16'd100, 16'd300, 2'd3, lat, pulses, val, bs);
`ifdef WAVE_NOISE_EN
      exp = lfsr_m[15:8];
`else
      exp = 8'h80;
`endif
      checks += 3;
      if (lat !== 9) begin failures++; $display("FAIL noise_latency actual=%0d required=9", lat); end
      if (pulses !== 1) begin failures++; $display("FAIL noise_pulses actual=%0d required=1", pulses); end
      if (val !== exp) begin failures++; $display("FAIL noise_value actual=%h required=%h", val, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_tri_square();
    test_div_zero();
    test_reset_mid_div();
    test_back_to_back();
    test_enable_drop();
    test_noise();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_shaper.md
Name: wave_shaper

Overview:
- Downstream consumer of the oscillator phase counter.
- On each audio sample strobe, snapshots the oscillator's count and divider, and computes a normalised 8-bit phase (count*256/divider) with a serial restoring divider.
- Maps that phase to an 8-bit unsigned waveform sample according to the selected mode.
- Feeds the mixer/PWM output stage with one valid-pulsed sample per strobe.

Parameters:
- DIV_STEPS, 8, quotient bits produced by the serial divider (equals the sample width; fixed at 8 for this design).
- MIDSCALE, 8'h80, silence/idle output value.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- enable  input  1  voice enable; low aborts and silences
- sample_tick  input  1  one-cycle sample-rate strobe
- count  input  16  oscillator phase counter value
- divider  input  16  oscillator period (same value driven to the oscillator)
- mode  input  2  0=square, 1=saw, 2=triangle, 3=noise/silence
- sample  output  8  registered waveform sample, unsigned
- sample_valid  output  1  one-cycle pulse when sample updates
- busy  output  1  high while in DIV or SHAPE

Behaviour:
- Reset (async, n_rst low) drives:
  - sample=MIDSCALE, sample_valid=0, busy=0
  - state=IDLE, all datapath registers 0
- FSM states and transitions:
  - IDLE -> DIV on clock edge E0 when enable=1 and sample_tick=1. At E0, latch count->C, divider->D and mode->M. The step counter is loaded with 0.
  - DIV: 8 edges (E1..E8), one quotient bit per edge, MSB first.
    - Restoring step: R = R<<1 (17-bit); if R>=D then R = R-D and qbit=1, else qbit=0.
    - R is initialised to C at E0.
  - SHAPE: at E9, sample is written from the quotient Q per M. sample_valid=1 for the cycle after E9 only. State returns to IDLE.
  - Latency: tick sampled at E0 -> sample/valid visible after E9 (9 clocks).
- Special cases, decided at E0 and forcing Q in DIV without changing the cycle count:
  - D==0: Q=8'h00.
  - C>=D: Q=8'hFF (clamp; covers count==divider at wrap).
- Shape mapping (Q = phase):
  - square: Q[7]=0 -> 8'hFF, else 8'h00
  - saw: Q
  - triangle: Q[7]=0 -> {Q[6:0],0}, else {~Q[6:0],0}
  - mode 3: see Optional Feature
- busy=1 in DIV and SHAPE.
- sample_tick while busy is ignored (dropped, no queueing).
- count, divider and mode changes mid-computation do not affect the in-flight result; they are latched at E0.
- enable low in any state: at the next edge, state=IDLE, sample=MIDSCALE, sample_valid=0, no partial result emitted.
- A tick coincident with enable low is ignored.
- sample holds its value between updates.

Optional Feature:
- Macro: WAVE_NOISE_EN.
- Defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11, seed 16'hACE1 on reset) advances one step at each accepted tick (E0).
  - mode 3 outputs LFSR[15:8] at E9; the divider still runs for uniform latency.
- Undefined:
  - No LFSR is present.
  - mode 3 outputs MIDSCALE with the same 9-clock latency and valid pulse.

Decomposition:
- Shared package synth_pkg:
  - wave_mode_t enum (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_NOISE)
  - shaper_state_t enum (IDLE, DIV, SHAPE)
  - MIDSCALE and LFSR_SEED constants
- One natural sub-module: serial_divider (start, C, D -> 8-bit quotient, done), instantiated once. Shape mapping and FSM remain in wave_shaper.

Test Plan:
- Reset mid-DIV (assert n_rst low at E4) -> sample=8'h80, valid=0 and busy=0 immediately. The next tick after release computes normally.
- mode=1, divider=1000, count=500, tick -> sample=8'h80 with valid exactly 9 clocks after tick. count=250 -> 8'h40. count=1000 -> 8'hFF (clamp).
- mode=2, divider=256: count=64 -> 8'h80; count=192 -> 8'h7E. mode=0: count=64 -> 8'hFF; count=192 -> 8'h00.
- divider=0, any count, mode=1 -> sample=8'h00 after 9 clocks, no hang.
- Second tick at E3 of a computation -> ignored: exactly one valid pulse, and the result reflects the E0 snapshot although count/divider changed at E2.
- enable dropped at E5 -> sample=8'h80 next edge, no valid pulse. mode=3 -> LFSR-derived samples (WAVE_NOISE_EN) or constant 8'h80 (undefined), both with a 9-clock valid.
